// File: rtl/iter_divider.sv
// Radix-2 restoring integer divider for div.w/mod.w/div.wu/mod.wu.
// Fixed WIDTH-cycle iteration. Quotient and remainder are returned together with a one-cycle div_ready pulse.
module iter_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_ready,
    output logic             stall_divider
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] dvd_q,       dvd_d;
    logic [WIDTH-1:0] dsr_q,       dsr_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] raw_q,       raw_d;
    logic             q_neg_q,     q_neg_d;
    logic             r_neg_q,     r_neg_d;
    logic             divzero_q,   divzero_d;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;
    logic             div_ready_d;

    // One restoring step: dvd_q shifts the dividend out at the top and the quotient in at the bottom.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign q_bit     = (rem_shift >= {1'b0, dsr_q});
    assign rem_sub   = rem_shift[WIDTH-1:0] - dsr_q;
    assign rem_next  = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
    assign q_next    = {dvd_q[WIDTH-2:0], q_bit};

    assign stall_divider = (state_q != IDLE);

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        raw_d       = raw_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        divzero_d   = divzero_q;
        quotient_d  = quotient;
        remainder_d = remainder;
        div_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (div_start && !flush) begin
                    dvd_d     = (div_signed && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
                    dsr_d     = (div_signed && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
                    rem_d     = '0;
                    raw_d     = dividend;
                    q_neg_d   = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d   = div_signed & dividend[WIDTH-1];
                    divzero_d = (divisor == '0);
                    cnt_d     = CNT_W'(WIDTH - 1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    dvd_d = q_next;
                    rem_d = rem_next;
                    if (cnt_q == '0) begin
                        state_d     = DONE;
                        div_ready_d = 1'b1;
                        // Divide-by-zero result overrides the sign fix-up.
                        if (divzero_q) begin
                            quotient_d  = '1;
                            remainder_d = raw_q;
                        end else begin
                            quotient_d  = q_neg_q ? WIDTH'(-q_next)   : q_next;
                            remainder_d = r_neg_q ? WIDTH'(-rem_next) : rem_next;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            raw_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            divzero_q <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            raw_q     <= raw_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            divzero_q <= divzero_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
            div_ready <= div_ready_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: table of operand/result vectors plus flush, busy-start and reset sequences.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_ready;
    logic        stall_divider;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          busy;
    } vec_t;

    vec_t vecs[11];

    iter_divider #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .dividend      (dividend),
        .divisor       (divisor),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_ready     (div_ready),
        .stall_divider (stall_divider)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation at the current negedge and watch 40 cycles after the accepting edge.
    task automatic run(input string name, input vec_t v, input int flush_at,
                       input logic [31:0] prev_q, input logic [31:0] prev_r);
        int rdy_cyc;
        int rdy_cnt;
        bit stall_ok;
        bit exp_stall;
        rdy_cyc  = -1;
        rdy_cnt  = 0;
        stall_ok = 1'b1;
        div_start  = 1'b1;
        div_signed = v.sgn;
        dividend   = v.a;
        divisor    = v.b;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        for (int k = 1; k <= 40; k++) begin
            if (div_ready === 1'b1) begin
                rdy_cnt++;
                rdy_cyc = k;
            end
            exp_stall = (flush_at > 0) ? (k <= flush_at) : (k <= 33);
            if (stall_divider !== exp_stall) stall_ok = 1'b0;
            flush     = (flush_at > 0) && (k == flush_at);
            div_start = v.busy && (k == 5 || k == 6 || k == 20 || k == 33);
            if (v.busy) begin
                div_signed = ~v.sgn;
                dividend   = $urandom;
                divisor    = 32'(k);
            end
            @(negedge clk);
        end
        div_start = 1'b0;
        flush     = 1'b0;
        if (flush_at == 0) begin
            chk({name, " ready_cycle"}, 32'(rdy_cyc), 32'd33);
            chk({name, " ready_count"}, 32'(rdy_cnt), 32'd1);
            chk({name, " stall"},       32'(stall_ok), 32'd1);
            chk({name, " quotient"},    quotient,  v.q);
            chk({name, " remainder"},   remainder, v.r);
        end else begin
            chk({name, " ready_count"}, 32'(rdy_cnt), 32'd0);
            chk({name, " stall"},       32'(stall_ok), 32'd1);
            chk({name, " quotient_hold"},  quotient,  prev_q);
            chk({name, " remainder_hold"}, remainder, prev_r);
        end
    endtask

    initial begin
        int rdy_cnt;
        vec_t fv;

        //          sgn   dividend       divisor        quotient       remainder      busy
        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
        vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
        vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
        vecs[5]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
        vecs[6]  = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b0};
        vecs[7]  = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b1};
        vecs[9]  = '{1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b0};

        reset = 1'b1; flush = 1'b0; div_start = 1'b0; div_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset quotient",  quotient,  32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset ready",     32'(div_ready),     32'd0);
        chk("reset stall",     32'(stall_divider), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run($sformatf("vec%0d", i), vecs[i], 0, 32'd0, 32'd0);
        end

        // Flush at cycle 10 of 100/7: outputs keep vecs[10]'s result, then 9/4 runs normally.
        fv = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        run("flush", fv, 10, vecs[10].q, vecs[10].r);
        fv = '{1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0};
        run("after_flush", fv, 0, 32'd0, 32'd0);
        fv = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        run("flush_last", fv, 32, 32'd2, 32'd1);

        // Reset in the middle of an operation.
        div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) reset = 1'b1;
            @(negedge clk);
        end
        chk("midreset quotient",  quotient,  32'd0);
        chk("midreset remainder", remainder, 32'd0);
        chk("midreset ready",     32'(div_ready),     32'd0);
        chk("midreset stall",     32'(stall_divider), 32'd0);
        reset = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (div_ready === 1'b1) rdy_cnt++;
            @(negedge clk);
        end
        chk("midreset no_ready", 32'(rdy_cnt), 32'd0);

        // flush and div_start together in IDLE: request dropped.
        flush = 1'b1; div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; div_start = 1'b0;
        chk("idle_flush stall", 32'(stall_divider), 32'd0);
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (div_ready === 1'b1) rdy_cnt++;
            @(negedge clk);
        end
        chk("idle_flush no_ready",  32'(rdy_cnt), 32'd0);
        chk("idle_flush quotient",  quotient,  32'd0);
        chk("idle_flush remainder", remainder, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
